// File: rtl/lif_neuron_array.sv
// lif_neuron_array
// Parallel array of N_CH leaky integrate-and-fire neurons. On every cycle
// with step_en high, each channel leaks by state >> LEAK_SHIFT, integrates
// its own input current with saturation, and fires when the result reaches
// its effective threshold. After a spike the membrane is forced to RESET_V
// and held there for REFRAC steps.
//
// Optional feature macro: ADAPT_THR_EN
//   When defined, each channel keeps an adaptive threshold offset. The offset
//   grows by ADAPT_STEP (saturating) on a spike and shrinks by 1 (floor 0) on
//   every other step. When undefined, thr_eff = thr_i and no offset exists.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset, overrides step_en
//   step_en      one-cycle strobe, advances every neuron by one step
//   cur_i        per-channel unsigned current, channel c at [c*WIDTH +: WIDTH]
//   thr_i        shared unsigned firing threshold
//   mem_sel_i    channel index for membrane readout
//   spike_o      registered spike vector, one bit per channel
//   spike_cnt_o  registered popcount of spike_o
//   mem_o        registered membrane value of the selected channel
//                (0 when mem_sel_i >= N_CH)
module lif_neuron_array #(
  parameter int N_CH       = 4,
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 2,
  parameter int RESET_V    = 0,
  parameter int ADAPT_STEP = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   step_en,
  input  logic [N_CH*WIDTH-1:0]                  cur_i,
  input  logic [WIDTH-1:0]                       thr_i,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] mem_sel_i,
  output logic [N_CH-1:0]                        spike_o,
  output logic [$clog2(N_CH+1)-1:0]              spike_cnt_o,
  output logic [WIDTH-1:0]                       mem_o
);

  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(N_CH + 1);
  localparam int REF_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_V);
  localparam logic [REF_W-1:0] REF_VAL = REF_W'(REFRAC);

  // Unsigned add clamped to the all-ones value of WIDTH bits.
  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[WIDTH]) begin
      return {WIDTH{1'b1}};
    end else begin
      return sum[WIDTH-1:0];
    end
  endfunction

  logic [WIDTH-1:0] state_q [N_CH];
  logic [WIDTH-1:0] state_d [N_CH];
  logic [REF_W-1:0] refr_q  [N_CH];
  logic [REF_W-1:0] refr_d  [N_CH];
  logic [N_CH-1:0]  spike_q, spike_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q, mem_d;

  logic [WIDTH:0]   sum_s     [N_CH];
  logic [WIDTH-1:0] next_s    [N_CH];
  logic [WIDTH-1:0] thr_eff_s [N_CH];

`ifdef ADAPT_THR_EN
  localparam logic [WIDTH-1:0] ADAPT_INC = WIDTH'(ADAPT_STEP);
  logic [WIDTH-1:0] adapt_q [N_CH];
  logic [WIDTH-1:0] adapt_d [N_CH];
`endif

  // Per-channel leak + integrate with saturation, and effective threshold.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      // state - leak never underflows, so WIDTH+1 bits hold the full sum.
      sum_s[c] = {1'b0, state_q[c]} - {1'b0, (state_q[c] >> LEAK_SHIFT)}
               + {1'b0, cur_i[c*WIDTH +: WIDTH]};
      if (sum_s[c][WIDTH]) begin
        next_s[c] = {WIDTH{1'b1}};
      end else begin
        next_s[c] = sum_s[c][WIDTH-1:0];
      end
`ifdef ADAPT_THR_EN
      thr_eff_s[c] = sat_add(thr_i, adapt_q[c]);
`else
      thr_eff_s[c] = thr_i;
`endif
    end
  end

  // Step decision per channel, spike popcount and readout mux.
  always_comb begin
    spike_d = '0;
    cnt_d   = '0;
    mem_d   = '0;
    for (int c = 0; c < N_CH; c++) begin
      state_d[c] = state_q[c];
      refr_d[c]  = refr_q[c];
    end
    if (step_en) begin
      for (int c = 0; c < N_CH; c++) begin
        if (refr_q[c] != '0) begin
          state_d[c] = RST_VAL;
          refr_d[c]  = refr_q[c] - REF_W'(1);
        end else if (next_s[c] >= thr_eff_s[c]) begin
          spike_d[c] = 1'b1;
          state_d[c] = RST_VAL;
          refr_d[c]  = REF_VAL;
        end else begin
          state_d[c] = next_s[c];
        end
      end
    end else begin
      spike_d = '0;
    end
    for (int c = 0; c < N_CH; c++) begin
      cnt_d = cnt_d + CNT_W'(spike_d[c]);
    end
    // Readout shows the post-step state so mem_o has one-cycle latency.
    for (int c = 0; c < N_CH; c++) begin
      if (mem_sel_i == SEL_W'(c)) begin
        mem_d = state_d[c];
      end else begin
        mem_d = mem_d;
      end
    end
  end

`ifdef ADAPT_THR_EN
  // Adaptive offset: jump on spike, decay by one on any other step.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      if (!step_en) begin
        adapt_d[c] = adapt_q[c];
      end else if (spike_d[c]) begin
        adapt_d[c] = sat_add(adapt_q[c], ADAPT_INC);
      end else if (adapt_q[c] != '0) begin
        adapt_d[c] = adapt_q[c] - WIDTH'(1);
      end else begin
        adapt_d[c] = adapt_q[c];
      end
    end
  end

  // Adaptive offset registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) adapt_q[c] <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) adapt_q[c] <= adapt_d[c];
    end
  end
`endif

  // Neuron state, refractory counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= RST_VAL;
        refr_q[c]  <= '0;
      end
      spike_q <= '0;
      cnt_q   <= '0;
      mem_q   <= RST_VAL;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        state_q[c] <= state_d[c];
        refr_q[c]  <= refr_d[c];
      end
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  assign spike_o     = spike_q;
  assign spike_cnt_o = cnt_q;
  assign mem_o       = mem_q;

endmodule

// File: doc/lif_neuron_array.md
Name: lif_neuron_array

Overview:
Parametrised multi-channel leaky integrate-and-fire (LIF) neuron array; next-generation replacement for the single-neuron Tiny Tapeout core. N_CH independent neurons update in parallel on each step_en strobe, each with shift-based leak, saturating integration, a runtime threshold and a refractory period. Sits behind the tt_um_* top-level: cur_i comes from input/config registers, spike_o drives uo_out, mem_o feeds a debug readout.

Parameters:
N_CH, 4, number of neuron channels (>=1)
WIDTH, 8, membrane/current/threshold width in bits
LEAK_SHIFT, 3, leak = state >> LEAK_SHIFT per step (1..WIDTH-1)
REFRAC, 2, refractory steps after a spike (0 = none)
RESET_V, 0, membrane value loaded on spike and held during refractory
ADAPT_STEP, 16, threshold increment per spike (ADAPT_THR_EN only)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
step_en  in  1  one-cycle strobe; advances every neuron by one time step
cur_i  in  N_CH*WIDTH  unsigned input current; channel c at [c*WIDTH +: WIDTH]
thr_i  in  WIDTH  unsigned firing threshold shared by all channels
mem_sel_i  in  max(1,$clog2(N_CH))  channel index for membrane readout
spike_o  out  N_CH  registered spike vector, one bit per channel
spike_cnt_o  out  $clog2(N_CH+1)  registered popcount of spike_o
mem_o  out  WIDTH  registered membrane value of channel mem_sel_i

Behaviour:
- Reset (rst=1 at a clock edge): all membrane states = RESET_V, refractory counters = 0, adaptive offsets = 0, spike_o = 0, spike_cnt_o = 0, mem_o = RESET_V. rst overrides step_en.
- step_en=0: states, counters and offsets hold; spike_o and spike_cnt_o are 0 on the next edge; mem_o continues tracking mem_sel_i.
- step_en=1, channel not refractory (counter==0):
  - next = state - (state >> LEAK_SHIFT) + cur, computed in WIDTH+1 bits, saturated to 2^WIDTH-1.
  - next >= thr_eff: spike bit = 1, state = RESET_V, counter = REFRAC.
  - else: spike bit = 0, state = next.
- step_en=1, channel refractory (counter>0): state held at RESET_V, cur ignored, counter decremented, spike bit 0.
- Latency: spike_o, spike_cnt_o and the new state (via mem_o) visible one cycle after the step_en edge.
- thr_eff = thr_i without ADAPT_THR_EN. thr_i = 0: every non-refractory step spikes.
- mem_o = state[mem_sel_i], registered; mem_sel_i >= N_CH gives mem_o = 0.
- Back-to-back step_en is legal; each asserted cycle is one step.
- No combinational path from inputs to outputs.

Optional Feature:
ADAPT_THR_EN defined:
- Per-channel WIDTH-bit offset adapt[c].
- thr_eff[c] = min(thr_i + adapt[c], 2^WIDTH-1).
- On a spike: adapt[c] += ADAPT_STEP, saturating.
- On a step with no spike (including refractory steps): adapt[c] decrements by 1, floor 0.
- Reset clears adapt[c].
ADAPT_THR_EN undefined: no offset registers; thr_eff = thr_i.

Test Plan:
(Defaults N_CH=4, WIDTH=8, LEAK_SHIFT=3, REFRAC=2, RESET_V=0.)
1. Reset: drive rst=1 for 2 cycles with random cur_i/step_en -> spike_o=0, spike_cnt_o=0, mem_o=0 for all mem_sel_i values.
2. Integrate/fire: ch0 cur=100, thr=128, step every cycle -> mem_o(sel=0) = 100 after step 1; step 2 gives 188 >= 128, so spike_o=4'b0001, spike_cnt_o=1, mem_o=0.
3. Refractory: continue test 2 stimulus -> steps 3 and 4: spike_o[0]=0, mem_o=0; step 5: mem_o=100; step 6: spike again.
4. Saturation: cur=200 on all channels, thr=255 -> step 1: mem=200, no spike; step 2: 375 saturates to 255, spike_o=4'b1111, spike_cnt_o=4.
5. Hold and mid-operation reset: deassert step_en for 10 cycles with cur=255 -> mem_o unchanged, spike_o=0. Then assert rst during refractory -> counters cleared, and the next step with cur=100 gives mem=100.
6. ADAPT_THR_EN, ADAPT_STEP=16: ch0 cur=100, thr=128 -> first spike at step 2; thr_eff becomes 144 and decays 1 per step; spike timing and offsets match the bench's reference model.
